// File: rtl/instr_fetch.sv
// Instruction fetch unit: issues single outstanding reads at pc, holds the returned word
// until the datapath acknowledges it, and follows branch/jump redirects.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        memReq,
  output logic [31:0] memAddr,
  input  logic        memReady,
  input  logic [31:0] memData,
  output logic [31:0] instr,
  output logic [31:0] instrPc,
  output logic        instrValid,
  input  logic        instrAck,
  input  logic        redirect,
  input  logic [31:0] redirectPc,
  output logic [31:0] pc,
  output logic        fault,
  output logic [31:0] fetchCount
);

  typedef enum logic [1:0] {StIdle, StReq, StHold, StHalt} state_e;

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] instr_q;
  logic [31:0] instr_pc_q;
  logic        valid_q;
  logic        req_q;
  logic        fault_q;
  logic [31:0] count_q;
  logic        misaligned;

  assign misaligned = |redirectPc[1:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      pc_q       <= RESET_PC;
      instr_q    <= 32'h0;
      instr_pc_q <= 32'h0;
      valid_q    <= 1'b0;
      req_q      <= 1'b0;
      fault_q    <= 1'b0;
      count_q    <= 32'h0;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_q <= StReq;
          req_q   <= 1'b1;
        end
        StReq: begin
          // Redirect beats memReady: the returned word belongs to the abandoned path.
          if (redirect) begin
            if (misaligned) begin
              state_q <= StHalt;
              req_q   <= 1'b0;
              fault_q <= 1'b1;
            end else begin
              pc_q <= redirectPc;
            end
          end else if (memReady) begin
            instr_q    <= memData;
            instr_pc_q <= pc_q;
            state_q    <= StHold;
            req_q      <= 1'b0;
            valid_q    <= 1'b1;
          end
        end
        StHold: begin
          // An acknowledged word is consumed even when a redirect arrives alongside it.
          if (instrAck) count_q <= count_q + 32'd1;
          if (redirect) begin
            valid_q <= 1'b0;
            if (misaligned) begin
              state_q <= StHalt;
              fault_q <= 1'b1;
            end else begin
              pc_q    <= redirectPc;
              state_q <= StReq;
              req_q   <= 1'b1;
            end
          end else if (instrAck) begin
            pc_q    <= pc_q + 32'd4;
            state_q <= StReq;
            req_q   <= 1'b1;
            valid_q <= 1'b0;
          end
        end
        StHalt: begin
          state_q <= StHalt;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign memReq     = req_q;
  assign memAddr    = pc_q;
  assign pc         = pc_q;
  assign instr      = instr_q;
  assign instrPc    = instr_pc_q;
  assign instrValid = valid_q;
  assign fault      = fault_q;
  assign fetchCount = count_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: a scoreboard queue holds expected fetched words, a monitor
// pops and compares them whenever the datapath consumes an instruction.
module tb_instr_fetch;

  logic        clk;
  logic        rst_n;
  logic        memReq;
  logic [31:0] memAddr;
  logic        memReady;
  logic [31:0] memData;
  logic [31:0] instr;
  logic [31:0] instrPc;
  logic        instrValid;
  logic        instrAck;
  logic        redirect;
  logic [31:0] redirectPc;
  logic [31:0] pc;
  logic        fault;
  logic [31:0] fetchCount;

  typedef struct {
    logic [31:0] word;
    logic [31:0] addr;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  instr_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .memReq     (memReq),
    .memAddr    (memAddr),
    .memReady   (memReady),
    .memData    (memData),
    .instr      (instr),
    .instrPc    (instrPc),
    .instrValid (instrValid),
    .instrAck   (instrAck),
    .redirect   (redirect),
    .redirectPc (redirectPc),
    .pc         (pc),
    .fault      (fault),
    .fetchCount (fetchCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Consumption monitor: every acknowledged valid word must match the scoreboard head.
  always @(negedge clk) begin
    if (instrValid && instrAck) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: got instr %h at %h expected none", instr, instrPc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("sb_instr", instr, e.word);
        check("sb_pc", instrPc, e.addr);
      end
    end
  end

  // Starts in REQ at address a; returns data d, optionally acknowledges it.
  task automatic fetch(input logic [31:0] d, input logic [31:0] a, input bit ack);
    exp_t e;
    check("req_addr", memAddr, a);
    check("req_memreq", {31'b0, memReq}, 32'd1);
    memReady = 1'b1;
    memData  = d;
    tick();
    memReady = 1'b0;
    memData  = 32'h0;
    check("hold_valid", {31'b0, instrValid}, 32'd1);
    check("hold_instr", instr, d);
    check("hold_pc", instrPc, a);
    check("hold_memreq", {31'b0, memReq}, 32'd0);
    e.word = d;
    e.addr = a;
    exp_q.push_back(e);
    if (ack) begin
      instrAck = 1'b1;
      tick();
      instrAck = 1'b0;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n      = 1'b0;
    memReady   = 1'b0;
    memData    = 32'h0;
    instrAck   = 1'b0;
    redirect   = 1'b0;
    redirectPc = 32'h0;
    tick();
    tick();
    check("rst_memreq", {31'b0, memReq}, 32'd0);
    check("rst_valid", {31'b0, instrValid}, 32'd0);
    check("rst_pc", pc, 32'h0);
    check("rst_memaddr", memAddr, 32'h0);
    check("rst_fault", {31'b0, fault}, 32'd0);
    check("rst_count", fetchCount, 32'h0);
    check("rst_instr", instr, 32'h0);
    check("rst_instrpc", instrPc, 32'h0);

    // Release with a redirect present: IDLE must ignore it.
    rst_n      = 1'b1;
    redirect   = 1'b1;
    redirectPc = 32'h80;
    tick();
    redirect = 1'b0;
    check("rel_memreq", {31'b0, memReq}, 32'd1);
    check("idle_redirect_ignored", memAddr, 32'h0);
    tick();
    check("wait_memaddr", memAddr, 32'h0);
    check("wait_valid", {31'b0, instrValid}, 32'd0);

    fetch(32'h0050_0093, 32'h0, 1'b0);
    tick();
    check("stall_valid", {31'b0, instrValid}, 32'd1);
    check("stall_instr", instr, 32'h0050_0093);
    check("stall_pc", pc, 32'h0);
    instrAck = 1'b1;
    tick();
    instrAck = 1'b0;
    check("seq_count1", fetchCount, 32'd1);
    fetch(32'h0010_0113, 32'h4, 1'b1);
    fetch(32'h0020_8193, 32'h8, 1'b1);
    check("seq_addr12", memAddr, 32'hC);
    check("seq_count3", fetchCount, 32'd3);

    // Redirect coincident with memReady drops the word.
    redirect   = 1'b1;
    redirectPc = 32'h40;
    memReady   = 1'b1;
    memData    = 32'hDEAD_BEEF;
    tick();
    redirect = 1'b0;
    memReady = 1'b0;
    memData  = 32'h0;
    check("drop_valid", {31'b0, instrValid}, 32'd0);
    check("drop_memreq", {31'b0, memReq}, 32'd1);
    check("drop_memaddr", memAddr, 32'h40);
    tick();
    check("drop_valid2", {31'b0, instrValid}, 32'd0);
    fetch(32'h0000_0013, 32'h40, 1'b0);

    // Redirect together with ack in HOLD: counted, pc takes the target.
    redirect   = 1'b1;
    redirectPc = 32'h100;
    instrAck   = 1'b1;
    tick();
    redirect = 1'b0;
    instrAck = 1'b0;
    check("rdack_count", fetchCount, 32'd4);
    check("rdack_pc", pc, 32'h100);
    check("rdack_valid", {31'b0, instrValid}, 32'd0);
    check("rdack_memreq", {31'b0, memReq}, 32'd1);

    // pc and fetchCount wrap.
    redirect   = 1'b1;
    redirectPc = 32'hFFFF_FFFC;
    tick();
    redirect = 1'b0;
    check("wrap_addr", memAddr, 32'hFFFF_FFFC);
    fetch(32'h1111_1111, 32'hFFFF_FFFC, 1'b0);
    force dut.count_q = 32'hFFFF_FFFF;
    #1;
    release dut.count_q;
    check("wrap_preset", fetchCount, 32'hFFFF_FFFF);
    instrAck = 1'b1;
    tick();
    instrAck = 1'b0;
    check("wrap_pc", pc, 32'h0);
    check("wrap_count", fetchCount, 32'h0);

    // Reset in HOLD with ack asserted.
    fetch(32'h2222_2222, 32'h0, 1'b0);
    rst_n    = 1'b0;
    instrAck = 1'b1;
    tick();
    instrAck = 1'b0;
    check("rsthold_valid", {31'b0, instrValid}, 32'd0);
    check("rsthold_count", fetchCount, 32'h0);
    check("rsthold_memreq", {31'b0, memReq}, 32'd0);
    rst_n = 1'b1;
    tick();
    check("rsthold_idle_to_req", {31'b0, memReq}, 32'd1);

    // Misaligned redirect halts with fault until reset.
    redirect   = 1'b1;
    redirectPc = 32'h20;
    tick();
    redirectPc = 32'h42;
    tick();
    redirect = 1'b0;
    check("fault_set", {31'b0, fault}, 32'd1);
    check("fault_memreq", {31'b0, memReq}, 32'd0);
    check("fault_pc", pc, 32'h20);
    check("fault_valid", {31'b0, instrValid}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      memReady   = 1'b1;
      redirect   = 1'b1;
      redirectPc = 32'h10;
      instrAck   = 1'b1;
      tick();
      check("halt_memreq", {31'b0, memReq}, 32'd0);
      check("halt_pc", pc, 32'h20);
      check("halt_fault", {31'b0, fault}, 32'd1);
    end
    memReady = 1'b0;
    redirect = 1'b0;
    instrAck = 1'b0;
    rst_n    = 1'b0;
    tick();
    check("halt_rst_fault", {31'b0, fault}, 32'd0);
    check("halt_rst_pc", pc, 32'h0);
    rst_n = 1'b1;
    tick();
    check("halt_rst_memreq", {31'b0, memReq}, 32'd1);

    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL set the PC loaded on reset.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  SHALL be a synchronous, active-low reset.
REQ-004 memReq  output  1  SHALL mean an instruction memory read is requested at memAddr.
REQ-005 memAddr  output  32  SHALL carry the fetch address; it equals pc while memReq=1.
REQ-006 memReady  input  1  SHALL mean memData is valid for the current request this cycle.
REQ-007 memData  input  32  SHALL carry the instruction word returned by memory.
REQ-008 instr  output  32  SHALL carry the held instruction word for the CPU datapath.
REQ-009 instrPc  output  32  SHALL carry the address instr was fetched from.
REQ-010 instrValid  output  1  SHALL mean instr/instrPc are valid and awaiting consumption.
REQ-011 instrAck  input  1  SHALL mean the datapath consumes instr this cycle; it is ignored when instrValid=0.
REQ-012 redirect  input  1  SHALL request a PC change, driven by taken branch/jump (PCSel path).
REQ-013 redirectPc  input  32  SHALL carry the redirect target (ALU output).
REQ-014 pc  output  32  SHALL carry the current fetch PC.
REQ-015 fault  output  1  SHALL flag a misaligned redirect; it is sticky until reset.
REQ-016 fetchCount  output  32  SHALL count instructions accepted via instrAck.

Function
REQ-017 The FSM SHALL have the states IDLE, REQ, HOLD and HALT; memReq=1 only in REQ, and instrValid=1 only in HOLD.
REQ-018 IDLE->REQ SHALL occur on the first clock edge with rst_n=1, so memReq rises one cycle after reset release.
REQ-019 In REQ with memReady=1 and redirect=0: instr<=memData, instrPc<=pc, and the next state SHALL be HOLD (one-cycle latency from memReady to instrValid).
REQ-020 In REQ with memReady=0: the FSM SHALL stay in REQ with memAddr held stable.
REQ-021 In HOLD with instrAck=1 and redirect=0: pc<=pc+4 (mod 2^32; 32'hFFFF_FFFC wraps to 0), fetchCount<=fetchCount+1 (wraps), and the next state SHALL be REQ.
REQ-022 In HOLD with instrAck=0: instr, instrPc and pc SHALL hold unchanged.
REQ-023 A redirect with redirectPc[1:0]=2'b00 in REQ or HOLD SHALL set pc<=redirectPc and next state REQ, and SHALL take priority over memReady and instrAck.
REQ-024 A redirect in REQ coincident with memReady=1 SHALL discard memData; instr and instrValid stay unchanged and the next state is REQ.
REQ-025 A redirect in HOLD coincident with instrAck=1 SHALL count the acknowledged instruction (fetchCount+1) and load pc<=redirectPc, not pc+4.
REQ-026 A redirect with redirectPc[1:0]!=0 SHALL set fault<=1 and state HALT, leaving pc unchanged.
REQ-027 In HALT: memReq=0, instrValid=0, and all inputs except rst_n SHALL be ignored.
REQ-028 A redirect in IDLE SHALL be ignored.
REQ-029 A redirect withdraws any outstanding request; the memory SHALL tolerate a request abandoned before memReady.

Reset
REQ-030 A clock edge with rst_n=0 SHALL set: state=IDLE, pc=RESET_PC, instr=0, instrPc=0, instrValid=0, memReq=0, fault=0, fetchCount=0, regardless of current state (including mid-request or HALT).
REQ-031 memAddr SHALL equal pc in all states, so it reads RESET_PC after reset.

Verification
REQ-032 Reset release, memory ready 2 cycles after request with data 32'h00500093 -> memReq rises 1 cycle after release with memAddr=0; instrValid=1, instr=32'h00500093, instrPc=0.
REQ-033 Ack 3 sequential instructions -> memAddr sequence 0, 4, 8, 12; fetchCount=3.
REQ-034 Redirect to 32'h40 in REQ on the same cycle as memReady -> data dropped, no instrValid; next memAddr=32'h40.
REQ-035 Redirect to 32'h42 -> fault=1, memReq=0 permanently; a following rst_n=0 clears fault and pc=RESET_PC.
REQ-036 pc=32'hFFFF_FFFC, ack -> pc=0; fetchCount at 32'hFFFF_FFFF, ack -> 0.
REQ-037 rst_n=0 asserted in HOLD with instrAck=1 -> after the edge, instrValid=0, fetchCount=0, state IDLE.
